// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC, synchronous-ROM latency, one-entry stall skid, two-bubble redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/flush_count outputs.
module fetch_sequencer #(
  parameter int                 WIDTH_B = 32,
  parameter int                 ADDR_B  = 10,
  parameter logic [WIDTH_B-1:0] NOP     = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_valid,
  input  logic               redirect_kind,
  input  logic [WIDTH_B-1:0] redirect_pc,
  input  logic [WIDTH_B-1:0] redirect_imm,
  output logic [ADDR_B-1:0]  rom_addr,
  input  logic [WIDTH_B-1:0] rom_data,
  output logic               if_valid,
  output logic [WIDTH_B-1:0] if_instr,
  output logic [WIDTH_B-1:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count,
`endif
  output logic [WIDTH_B-1:0] pc_debug
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} state_t;

  state_t             state;
  logic [WIDTH_B-1:0] pc_r;
  logic [WIDTH_B-1:0] pc_d1;
  logic               inflight_valid;
  logic               skid_valid;
  logic [WIDTH_B-1:0] skid_instr;
  logic [WIDTH_B-1:0] skid_pc;

  logic [WIDTH_B-1:0] pc_inc;
  logic [WIDTH_B-1:0] target;
  logic               advance;
  logic               stall_entry;

  always_comb begin
    pc_inc = redirect_pc + 1'b1;
    if (redirect_kind)
      target = {pc_inc[WIDTH_B-1:26], redirect_imm[25:0]};
    else
      target = pc_inc + redirect_imm;
  end

  // Outside a redirect, any cycle without stall_i advances; only the first stalled cycle captures the skid.
  assign advance     = !redirect_valid && !stall_i;
  assign stall_entry = !redirect_valid && stall_i && (state != S_STALL);

  assign rom_addr = pc_r[ADDR_B-1:0];
  assign pc_debug = pc_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_BOOT;
      pc_r           <= '0;
      pc_d1          <= '0;
      inflight_valid <= 1'b0;
      skid_valid     <= 1'b0;
      skid_instr     <= NOP;
      skid_pc        <= '0;
      if_valid       <= 1'b0;
      if_instr       <= NOP;
      if_pc          <= '0;
    end else if (redirect_valid) begin
      state          <= S_RUN;
      pc_r           <= target;
      inflight_valid <= 1'b0;
      skid_valid     <= 1'b0;
      if_valid       <= 1'b0;
      if_instr       <= NOP;
    end else begin
      case (state)
        S_BOOT:  state <= stall_i ? S_STALL : S_RUN;
        S_RUN:   state <= stall_i ? S_STALL : S_RUN;
        S_STALL: state <= stall_i ? S_STALL : S_RUN;
        default: state <= S_BOOT;
      endcase

      if (advance) begin
        pc_r           <= pc_r + 1'b1;
        pc_d1          <= pc_r;
        inflight_valid <= 1'b1;
        if (skid_valid) begin
          if_valid   <= 1'b1;
          if_instr   <= skid_instr;
          if_pc      <= skid_pc;
          skid_valid <= 1'b0;
        end else begin
          if_valid <= inflight_valid;
          if_instr <= rom_data;
          if_pc    <= pc_d1;
        end
      end else if (stall_entry) begin
        // pc_r holds, so the address in flight is simply re-presented after release.
        if (inflight_valid) begin
          skid_valid <= 1'b1;
          skid_instr <= rom_data;
          skid_pc    <= pc_d1;
        end
        inflight_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;
  assign load_valid = advance && (skid_valid || inflight_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (load_valid && (fetch_count != '1))
        fetch_count <= fetch_count + 1'b1;
      if (redirect_valid && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer with a behavioural synchronous ROM (mem[i] = i + 0x100).
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic        redirect_kind;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc_debug;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .flush_count    (flush_count),
`endif
    .pc_debug       (pc_debug)
  );

  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
  always @(posedge clk) rom_data <= mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic        rk;
    logic [31:0] rpc;
    logic [31:0] rimm;
    logic        ev;   // expected if_valid
    logic        ci;   // check if_instr even when invalid
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] epc;  // expected pc_debug
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic stall, rv, rk, input logic [31:0] rpc, rimm,
                              input logic ev, ci, input logic [31:0] ei, ep, epc);
    vec_t v;
    v.stall = stall; v.rv = rv; v.rk = rk; v.rpc = rpc; v.rimm = rimm;
    v.ev = ev; v.ci = ci; v.ei = ei; v.ep = ep; v.epc = epc;
    return v;
  endfunction

  task automatic drive(input logic stall, rv, rk, input logic [31:0] rpc, rimm);
    stall_i = stall; redirect_valid = rv; redirect_kind = rk;
    redirect_pc = rpc; redirect_imm = rimm;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, " if_instr"}, if_instr, 32'd0);
    chk({tag, " if_pc"}, if_pc, 32'd0);
    chk({tag, " pc_debug"}, pc_debug, 32'd0);
    chk({tag, " rom_addr"}, {22'd0, rom_addr}, 32'd0);
  endtask

  task automatic step_chk(input string tag, input logic ev, input logic [31:0] ei, ep, epc);
    @(posedge clk); #1;
    chk({tag, " valid"}, {31'd0, if_valid}, {31'd0, ev});
    chk({tag, " pc_debug"}, pc_debug, epc);
    if (ev) begin
      chk({tag, " instr"}, if_instr, ei);
      chk({tag, " pc"}, if_pc, ep);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [31:0] ea;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);

    // boot, sequential fetch, 3-cycle stall at if_pc=5
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h100,0,2));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h101,1,3));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h102,2,4));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h103,3,5));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h104,4,6));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h105,5,7));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 1,1,32'h105,5,7));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h106,6,8));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h107,7,9));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h108,8,10));
    // branch at pc 10, imm -4 -> 7
    tbl.push_back(mk(0,1,0,10,32'hFFFF_FFFC, 0,1,0,0,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,8));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h107,7,9));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h108,8,10));
    // jump keeps upper 6 bits of pc+1
    tbl.push_back(mk(0,1,1,32'h0400_0003,32'h20, 0,1,0,0,32'h0400_0020));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,32'h0400_0021));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h120,32'h0400_0020,32'h0400_0022));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h121,32'h0400_0021,32'h0400_0023));
    // redirect together with stall, stall held two more cycles
    tbl.push_back(mk(1,1,0,32'h30,32'h10, 0,1,0,0,32'h41));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,0,32'h41));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,0,32'h41));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,32'h42));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h141,32'h41,32'h43));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h142,32'h42,32'h44));
    // stall fills skid, redirect during stall must discard it
    tbl.push_back(mk(1,0,0,0,0, 1,1,32'h142,32'h42,32'h44));
    tbl.push_back(mk(1,1,1,0,5, 0,1,0,0,5));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,6));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h105,5,7));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h106,6,8));
    // rom_addr wraps at 1024 words
    tbl.push_back(mk(0,1,1,0,32'h3FF, 0,1,0,0,32'h3FF));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,32'h400));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h4FF,32'h3FF,32'h401));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h100,32'h400,32'h402));
    // pc_r wraps at 2^32
    tbl.push_back(mk(0,1,0,32'hFFFF_FFFD,0, 0,1,0,0,32'hFFFF_FFFE));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,32'hFFFF_FFFF));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h4FE,32'hFFFF_FFFE,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h4FF,32'hFFFF_FFFF,1));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h100,0,2));

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.stall, v.rv, v.rk, v.rpc, v.rimm);
      @(posedge clk); #1;
      ea = {22'd0, v.epc[9:0]};
      chk($sformatf("vec%0d valid", i), {31'd0, if_valid}, {31'd0, v.ev});
      chk($sformatf("vec%0d pc_debug", i), pc_debug, v.epc);
      chk($sformatf("vec%0d rom_addr", i), {22'd0, rom_addr}, ea);
      if (v.ev || v.ci) chk($sformatf("vec%0d instr", i), if_instr, v.ei);
      if (v.ev) chk($sformatf("vec%0d pc", i), if_pc, v.ep);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midstall_reset");
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step_chk("reboot e1", 0, 0, 0, 1);
    step_chk("reboot e2", 1, 32'h100, 0, 2);
    step_chk("reboot e3", 1, 32'h101, 1, 3);

`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("fetch_count 10", fetch_count, 32'd10);
    chk("flush_count 0", {16'd0, flush_count}, 32'd0);
    drive(0, 1, 0, 32'h50, 0);
    @(posedge clk); @(negedge clk);
    drive(0, 1, 1, 32'h60, 32'h8);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("fetch_count after redirects", fetch_count, 32'd10);
    chk("flush_count 2", {16'd0, flush_count}, 32'd2);
    reset = 1'b1;
    #1;
    chk("fetch_count reset", fetch_count, 32'd0);
    chk("flush_count reset", {16'd0, flush_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls the instruction-fetch stage: owns the word-addressed program counter, drives the address of the synchronous instruction ROM, and handles the ROM's one-cycle read latency. It sequences hazard stalls through a one-entry skid buffer and resolves branch/jump redirects with a fixed two-bubble flush. Its registered outputs form the IF/ID pipeline register that feeds decode.

## Interface
- WIDTH_B, 32, datapath/PC width
- ADDR_B, 10, ROM address width; rom_addr = pc_r[ADDR_B-1:0]
- NOP, 32'h0000_0000, instruction word driven while if_valid=0

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard unit requests that IF/ID hold
- redirect_valid  in  1  single-cycle pulse, branch taken or jump
- redirect_kind  in  1  0 = branch (relative), 1 = jump (absolute)
- redirect_pc  in  WIDTH_B  PC of the redirecting instruction
- redirect_imm  in  WIDTH_B  sign-extended offset (branch) or target in bits [25:0] (jump)
- rom_addr  out  ADDR_B  ROM address, combinational from pc_r
- rom_data  in  WIDTH_B  ROM output; valid one cycle after the address
- if_valid  out  1  IF/ID holds a real instruction
- if_instr  out  WIDTH_B  fetched instruction
- if_pc  out  WIDTH_B  PC of if_instr
- pc_debug  out  WIDTH_B  pc_r, for debug

## Operation
- Internal state: pc_r, pc_d1 (address presented last cycle), inflight_valid, and skid (valid/instr/pc).
- FSM states: BOOT, RUN, STALL.
  - BOOT: entered from reset. Moves to RUN after one cycle.
  - RUN: moves to STALL when stall_i=1.
  - STALL: moves to RUN when stall_i=0.
- A redirect from any state goes to RUN.
- **Priority:** reset, then redirect_valid, then stall_i, then normal advance.
- **Normal advance (RUN, stall_i=0, no redirect):**
  - pc_r <= pc_r+1, pc_d1 <= pc_r, inflight_valid <= 1.
  - If skid valid: if_* <= skid and skid is cleared.
  - Otherwise: if_* <= {inflight_valid, rom_data, pc_d1}.
- **Stall entry (first stall_i=1 cycle):**
  - pc_r and if_* hold.
  - If inflight_valid, skid <= {rom_data, pc_d1}.
  - inflight_valid <= 0; the address presented this cycle is re-presented later.
- **STALL:** all registers hold. ROM data is ignored.
- **Redirect:**
  - pc_r <= target.
  - inflight_valid, skid valid and if_valid are all cleared; if_instr <= NOP.
  - If stall_i is also high, the redirect still applies.
- **Target arithmetic:**
  - Branch: redirect_pc + 1 + redirect_imm, mod 2^WIDTH_B.
  - Jump: {(redirect_pc+1)[31:26], redirect_imm[25:0]}.
- **Wrap:** pc_r wraps from 0xFFFFFFFF to 0; rom_addr wraps every 2^ADDR_B words.

## Timing
- **Reset values:**
  - pc_r=0, pc_d1=0, inflight_valid=0, skid valid=0, state=BOOT.
  - if_valid=0, if_instr=NOP, if_pc=0, pc_debug=0, rom_addr=0.
  - Counters (when compiled in) reset to 0.
- **Boot latency:** mem[0] appears on if_instr with if_valid=1 after the 2nd rising edge following reset deassertion. After that, one instruction per cycle.
- **Redirect at edge N:**
  - if_valid=0 after edges N and N+1.
  - mem[target] is valid after edge N+2, giving a 2-bubble penalty.
- **Stall:**
  - Outputs are frozen from the first stalled edge onward.
  - The first edge with stall_i=0 presents the next sequential instruction, taken from skid. No instruction is lost or duplicated.
- **Reset mid-stall or mid-redirect:** all state returns to its reset value immediately.

## Configuration
- FETCH_PERF_CNT_EN adds two outputs:
  - fetch_count[31:0]: increments on every edge that loads if_valid=1.
  - flush_count[15:0]: increments on every redirect.
  - Both saturate at all-ones.
- Without the macro these ports and their logic do not exist. All other behaviour is identical.

## Test plan
- Reset release, ROM preloaded mem[i]=i+0x100 -> if_instr=0x100 after edge 2, then 0x101, 0x102… with if_valid=1 every cycle.
- stall_i high for 3 cycles while if_pc=5 -> outputs frozen at pc 5; after release, next outputs are pc 6 then 7, no gap or duplicate.
- Branch at redirect_pc=10, imm=-4 -> two if_valid=0 cycles, then if_pc=7 with if_instr=mem[7].
- Jump with redirect_pc=0x0400_0003, imm=0x0000_0020 -> target 0x0400_0020, rom_addr=0x020.
- redirect_valid and stall_i high together -> redirect taken, skid cleared, target fetched once stall_i drops.
- With FETCH_PERF_CNT_EN: 10 fetches and 2 redirects -> fetch_count=10, flush_count=2. Mid-run reset -> both return to 0.
